// File: rtl/phys_reg_free_list_pkg.sv
// Shared types and sizing for the physical register free list and the rename history.
package phys_reg_free_list_pkg;

  localparam int NUM_A_REGS    = 32;
  localparam int NUM_P_REGS    = 48;
  localparam int MAX_FREE_REGS = 16;
  localparam int F_LIST_WDTH   = 4;
  localparam int PRN_W         = 6;
  localparam int DEPTH         = MAX_FREE_REGS;
  localparam int PTR_W         = F_LIST_WDTH + 1;

  typedef logic [PRN_W-1:0]     prn_t;
  typedef logic [F_LIST_WDTH:0] fl_ptr_t;

  // Rename-history checkpoint: the free-list head captured at rename time.
  typedef struct packed {
    logic    valid;
    fl_ptr_t fl_ptr;
  } hist_ptr_t;

  function automatic prn_t reset_prn(input int idx);
    return prn_t'(NUM_A_REGS + idx);
  endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit/recovery signal bundle for the free list; master = rename/ROB side, slave = free list.
interface phys_reg_free_list_if
  import phys_reg_free_list_pkg::*;
();

  logic    alloc_req;
  logic    alloc_ready;
  prn_t    alloc_prn;
  fl_ptr_t alloc_ptr;
  logic    free_valid;
  prn_t    free_prn;
  logic    flush_valid;
  fl_ptr_t flush_head_ptr;
  fl_ptr_t free_count;
  logic    err_double_free;

  modport master (
    output alloc_req, free_valid, free_prn, flush_valid, flush_head_ptr,
    input  alloc_ready, alloc_prn, alloc_ptr, free_count, err_double_free
  );

  modport slave (
    input  alloc_req, free_valid, free_prn, flush_valid, flush_head_ptr,
    output alloc_ready, alloc_prn, alloc_ptr, free_count, err_double_free
  );

endinterface

// File: rtl/phys_reg_free_list_dup_checker.sv
// Module free_list_dup_checker: in-list bitmap that flags a PRN released while already free.
// Only instantiated when FREE_LIST_DUP_CHECK_EN is defined.
module free_list_dup_checker
  import phys_reg_free_list_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pop_i,
  input  prn_t                 pop_prn_i,
  input  logic                 push_i,
  input  prn_t                 push_prn_i,
  input  logic                 flush_i,
  input  fl_ptr_t              flush_head_i,
  input  fl_ptr_t              tail_i,
  input  prn_t [DEPTH-1:0]     mem_i,
  output logic                 err_o
);

  localparam logic [NUM_P_REGS-1:0] IN_LIST_RST = {{DEPTH{1'b1}}, {NUM_A_REGS{1'b0}}};

  logic [NUM_P_REGS-1:0] in_list_q, in_list_d;
  logic                  err_q, err_d;
  fl_ptr_t               live;

  assign live  = tail_i - flush_head_i;
  assign err_o = err_q;

  // NOTE: every variable written here gets its default first, so no latch is inferred.
  always_comb begin
    logic [F_LIST_WDTH-1:0] rel;
    in_list_d = in_list_q;
    err_d     = err_q;
    rel       = '0;
    if (flush_i) begin
      // Rebuild from the surviving window [flush_head, tail) in a single cycle.
      in_list_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        rel = F_LIST_WDTH'(i) - flush_head_i[F_LIST_WDTH-1:0];
        if ({1'b0, rel} < live) in_list_d[mem_i[i]] = 1'b1;
      end
    end else if (pop_i) begin
      in_list_d[pop_prn_i] = 1'b0;
    end
    if (push_i) begin
      if (in_list_q[push_prn_i]) err_d = 1'b1;
      in_list_d[push_prn_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_list_q <= IN_LIST_RST;
      err_q     <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register numbers with checkpoint-restore of the head.
// Optional duplicate-free detection under macro FREE_LIST_DUP_CHECK_EN.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  phys_reg_free_list_if.slave  fl_if
);

  localparam fl_ptr_t FULL_COUNT = fl_ptr_t'(DEPTH);

  prn_t [DEPTH-1:0] mem_q;
  fl_ptr_t          head_q, head_d;
  fl_ptr_t          tail_q, tail_d;
  fl_ptr_t          count;
  logic             pop_fire;
  logic             push_fire;

  // The wrap bit makes tail - head span 0..DEPTH without ambiguity.
  assign count     = tail_q - head_q;
  assign pop_fire  = fl_if.alloc_req && fl_if.alloc_ready && !fl_if.flush_valid;
  assign push_fire = fl_if.free_valid && (count != FULL_COUNT);

  assign fl_if.alloc_ready = (count != '0);
  assign fl_if.alloc_prn   = mem_q[head_q[PTR_W-2:0]];
  assign fl_if.alloc_ptr   = head_q;
  assign fl_if.free_count  = count;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (fl_if.flush_valid) head_d = fl_if.flush_head_ptr;
    else if (pop_fire)     head_d = head_q + 1'b1;
    if (push_fire)         tail_d = tail_q + 1'b1;
  end

  // NOTE: the storage is reset because the list must come up full of PRNs NUM_A_REGS..NUM_P_REGS-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= reset_prn(i);
      head_q <= '0;
      tail_q <= {1'b1, {(PTR_W-1){1'b0}}};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (push_fire) mem_q[tail_q[PTR_W-2:0]] <= fl_if.free_prn;
    end
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  free_list_dup_checker u_dup_checker (
    .clk          (clk),
    .rst          (rst),
    .pop_i        (pop_fire),
    .pop_prn_i    (fl_if.alloc_prn),
    .push_i       (push_fire),
    .push_prn_i   (fl_if.free_prn),
    .flush_i      (fl_if.flush_valid),
    .flush_head_i (fl_if.flush_head_ptr),
    .tail_i       (tail_q),
    .mem_i        (mem_q),
    .err_o        (fl_if.err_double_free)
  );
`else
  assign fl_if.err_double_free = 1'b0;
`endif

  push_while_full_a: assert property (@(posedge clk) disable iff (rst)
    !(fl_if.free_valid && (count == FULL_COUNT)));

  count_bound_a: assert property (@(posedge clk) disable iff (rst)
    (count <= FULL_COUNT));

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Randomized and directed bench for phys_reg_free_list against a sequence-position model.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phys_reg_free_list_if fl_if ();

  phys_reg_free_list dut (
    .clk   (clk),
    .rst   (rst),
    .fl_if (fl_if)
  );

  int checks = 0;
  int errors = 0;

  // Model: every PRN ever placed in the list, by absolute sequence position.
  // The free set is hist[head_abs .. hist.size()-1].
  prn_t hist[$];
  int   head_abs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    return hist.size() - head_abs;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(prn_t'(32 + i));
    head_abs = 0;
  endtask

  task automatic compare(input string tag);
    check({tag, "_ready"}, 32'(fl_if.alloc_ready), 32'(m_count() != 0));
    check({tag, "_ptr"},   32'(fl_if.alloc_ptr),   32'(head_abs % 32));
    check({tag, "_count"}, 32'(fl_if.free_count),  32'(m_count()));
    if (m_count() != 0) check({tag, "_prn"}, 32'(fl_if.alloc_prn), 32'(hist[head_abs]));
`ifndef FREE_LIST_DUP_CHECK_EN
    check({tag, "_err"}, 32'(fl_if.err_double_free), 32'(0));
`endif
  endtask

  task automatic drive_idle();
    fl_if.alloc_req      = 1'b0;
    fl_if.free_valid     = 1'b0;
    fl_if.free_prn       = '0;
    fl_if.flush_valid    = 1'b0;
    fl_if.flush_head_ptr = '0;
  endtask

  // Called at posedge+1; rolls back k pops on flush.
  task automatic cycle(input logic req, input logic fv, input prn_t fprn,
                       input logic flv, input int k, input string tag);
    fl_if.alloc_req      = req;
    fl_if.free_valid     = fv;
    fl_if.free_prn       = fprn;
    fl_if.flush_valid    = flv;
    fl_if.flush_head_ptr = fl_ptr_t'(head_abs - k);
    #3;
    compare(tag);
    if (flv)                        head_abs = head_abs - k;
    else if (req && m_count() != 0) head_abs = head_abs + 1;
    if (fv) hist.push_back(fprn);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive_idle();
    #2;
    model_reset();
    compare(tag);
    check({tag, "_prn32"}, 32'(fl_if.alloc_prn), 32'd32);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();

    // 1: drain the reset contents in order
    do_reset("reset");
    for (int i = 0; i < DEPTH; i++) begin
      check("t1_prn_order", 32'(fl_if.alloc_prn), 32'(32 + i));
      cycle(1'b1, 1'b0, '0, 1'b0, 0, "t1");
    end
    check("t1_empty_ready", 32'(fl_if.alloc_ready), 32'd0);
    check("t1_empty_count", 32'(fl_if.free_count), 32'd0);

    // 2: push to an empty list is not visible to a same-cycle pop
    cycle(1'b1, 1'b1, prn_t'(5), 1'b0, 0, "t2_nobypass");
    check("t2_ready", 32'(fl_if.alloc_ready), 32'd1);
    check("t2_prn",   32'(fl_if.alloc_prn),   32'd5);

    // 3: pop three, then restore the head checkpoint
    do_reset("t3_rst");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0, 0, "t3_pop");
    check("t3_ptr", 32'(fl_if.alloc_ptr), 32'd3);
    cycle(1'b1, 1'b0, '0, 1'b1, 3, "t3_flush");
    check("t3_count", 32'(fl_if.free_count), 32'd16);
    check("t3_prn",   32'(fl_if.alloc_prn),   32'd32);

    // 4: full pointer wrap
    do_reset("t4_rst");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, '0, 1'b0, 0, "t4_pop_a");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, prn_t'(20 + i), 1'b0, 0, "t4_push");
    for (int i = 0; i < DEPTH; i++) begin
      check("t4_prn_order", 32'(fl_if.alloc_prn), 32'(20 + i));
      cycle(1'b1, 1'b0, '0, 1'b0, 0, "t4_pop_b");
    end
    check("t4_ptr_wrap", 32'(fl_if.alloc_ptr),  32'd0);
    check("t4_count",    32'(fl_if.free_count), 32'd0);

    // 5: simultaneous push and pop hold the count
    do_reset("t5_rst");
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b0, 0, "t5_fill");
    for (int i = 0; i < 10; i++) begin
      check("t5_count_hold", 32'(fl_if.free_count), 32'd8);
      cycle(1'b1, 1'b1, prn_t'($urandom_range(0, NUM_P_REGS-1)), 1'b0, 0, "t5_pp");
    end
    check("t5_count_end", 32'(fl_if.free_count), 32'd8);

    // 6: release of a PRN that is already free
    do_reset("t6_rst");
    cycle(1'b1, 1'b0, '0, 1'b0, 0, "t6_pop");
    cycle(1'b0, 1'b1, prn_t'(40), 1'b0, 0, "t6_dup");
    for (int i = 0; i < 3; i++) begin
`ifdef FREE_LIST_DUP_CHECK_EN
      check("t6_err_sticky", 32'(fl_if.err_double_free), 32'd1);
`else
      check("t6_err_off", 32'(fl_if.err_double_free), 32'd0);
`endif
      cycle(1'b0, 1'b0, '0, 1'b0, 0, "t6_idle");
    end
    do_reset("t6_rst2");
    check("t6_err_cleared", 32'(fl_if.err_double_free), 32'd0);

    // Random traffic with legal checkpoint flushes and occasional mid-run reset
    do_reset("rnd_rst");
    for (int n = 0; n < 3000; n++) begin
      logic req, fv, flv;
      int   k, kmax;
      req  = ($urandom_range(0, 99) < 60);
      fv   = ($urandom_range(0, 99) < 45) && (m_count() < DEPTH);
      flv  = ($urandom_range(0, 99) < 5);
      kmax = DEPTH - m_count() - (fv ? 1 : 0);
      if (kmax > head_abs) kmax = head_abs;
      k    = (flv && kmax > 0) ? $urandom_range(0, kmax) : 0;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #2;
        model_reset();
        compare("rnd_midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        cycle(req, fv, prn_t'($urandom_range(0, NUM_P_REGS-1)), flv, k, "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
